// File: rtl/risc_ctrl_pkg.sv
// Shared opcodes, state encoding and decode helpers for the RISC controller.
package risc_ctrl_pkg;

   // Opcodes are held as 32-bit constants so any opcode width compares cleanly.
   localparam logic [31:0] OP_HLT = 32'd0;
   localparam logic [31:0] OP_SKZ = 32'd1;
   localparam logic [31:0] OP_ADD = 32'd2;
   localparam logic [31:0] OP_AND = 32'd3;
   localparam logic [31:0] OP_XOR = 32'd4;
   localparam logic [31:0] OP_LDA = 32'd5;
   localparam logic [31:0] OP_STO = 32'd6;
   localparam logic [31:0] OP_JMP = 32'd7;
   localparam logic [31:0] OP_SUB = 32'd8;
   localparam logic [31:0] OP_OR  = 32'd9;
   localparam logic [31:0] OP_SKN = 32'd10;
   localparam logic [31:0] OP_NOP = 32'd11;

   typedef enum logic [3:0] {
      INST_ADDR  = 4'd0,
      INST_FETCH = 4'd1,
      INST_LOAD  = 4'd2,
      IDLE       = 4'd3,
      OP_ADDR    = 4'd4,
      OP_FETCH   = 4'd5,
      ALU_OP     = 4'd6,
      STORE      = 4'd7,
      HALTED     = 4'd8,
      RESUME     = 4'd9
   } state_t;

   // Opcodes that read an operand from memory and load the accumulator.
   function automatic logic is_alu_class(input logic [31:0] op);
      return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
             (op == OP_LDA) || (op == OP_SUB) || (op == OP_OR);
   endfunction

   // Anything past NOP is undefined and traps.
   function automatic logic is_illegal(input logic [31:0] op);
      return op > OP_NOP;
   endfunction

endpackage

// File: rtl/risc_stall_timer.sv
// Counts cycles stalled on mem_ready and flags a bus timeout.
module risc_stall_timer #(
   parameter int TIMEOUT = 15,
   parameter int TO_W    = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic count_en,
   input  logic mem_ready,
   output logic timeout
);

   // Counter value seen during the stall cycle that completes the budget.
   localparam logic [TO_W-1:0] LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

   logic [TO_W-1:0] cnt;

   // Stall counter: cleared when the FSM leaves the stall state, counts stalled cycles.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (count_en && !mem_ready) begin
         cnt <= cnt + 1'b1;
      end
   end

   // A late mem_ready in the final budget cycle wins over the timeout.
   assign timeout = (TIMEOUT > 0) && count_en && !mem_ready && (cnt == LAST);

endmodule

// File: rtl/risc_controller_ws.sv
// RISC CPU sequencer with wait states, bus timeout, illegal-op trap,
// single-step and resume-from-halt.
module risc_controller_ws
   import risc_ctrl_pkg::*;
#(
   parameter int OP_CODE_WIDTH = 4,
   parameter int TIMEOUT       = 15,
   parameter int TO_W          = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [OP_CODE_WIDTH-1:0] op_code,
   input  logic                     is_zero,
   input  logic                     is_neg,
   input  logic                     mem_ready,
   input  logic                     step_en,
   input  logic                     step,
   input  logic                     go,
   output logic                     sel,
   output logic                     rd,
   output logic                     ld_ir,
   output logic                     inc_pc,
   output logic                     ld_ac,
   output logic                     ld_pc,
   output logic                     wr,
   output logic                     data_e,
   output logic                     halt,
   output logic                     bus_err,
   output logic                     illegal_op,
   output logic [3:0]               state_o
);

   state_t      state;
   state_t      next_state;
   logic        skip_q;
   logic        resume_inc;
   logic [31:0] op;
   logic        op_alu;
   logic        op_illegal;
   logic        op_hlt;
   logic        op_sto;
   logic        op_jmp;
   logic        op_skip;
   logic        stalling;
   logic        timeout;

   assign op         = 32'(op_code);
   assign op_alu     = is_alu_class(op);
   assign op_illegal = is_illegal(op);
   assign op_hlt     = (op == OP_HLT);
   assign op_sto     = (op == OP_STO);
   assign op_jmp     = (op == OP_JMP);
   assign op_skip    = (op == OP_SKZ) || (op == OP_SKN);

   // States that wait on mem_ready for the current opcode.
   assign stalling = (state == INST_FETCH) ||
                     ((state == OP_FETCH) && op_alu) ||
                     ((state == STORE) && op_sto);

   risc_stall_timer #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_stall_timer (
      .clk       (clk),
      .rst       (rst),
      .clear     (next_state != state),
      .count_en  (stalling),
      .mem_ready (mem_ready),
      .timeout   (timeout)
   );

   // State register plus skip flag, sticky error flags and resume policy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= INST_ADDR;
         skip_q     <= 1'b0;
         bus_err    <= 1'b0;
         illegal_op <= 1'b0;
         resume_inc <= 1'b0;
      end else begin
         state <= next_state;
         if (state == OP_ADDR) begin
            skip_q <= ((op == OP_SKZ) && is_zero) || ((op == OP_SKN) && is_neg);
            if (op_illegal) illegal_op <= 1'b1;
            if (op_illegal || op_hlt) resume_inc <= 1'b1;
         end
         if (timeout) begin
            // Bus error resumes by refetching the same PC.
            bus_err    <= 1'b1;
            resume_inc <= 1'b0;
         end
         if ((state == HALTED) && go) begin
            bus_err    <= 1'b0;
            illegal_op <= 1'b0;
         end
      end
   end

   // Next-state and strobe decode from state, opcode and skip flag.
   always_comb begin
      next_state = state;
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_ac  = 1'b0;
      ld_pc  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      case (state)
         INST_ADDR: begin
            sel = 1'b1;
            if (!step_en || step) next_state = INST_FETCH;
         end
         INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
            if (mem_ready)    next_state = INST_LOAD;
            else if (timeout) next_state = HALTED;
         end
         INST_LOAD: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
            next_state = IDLE;
         end
         IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
            next_state = OP_ADDR;
         end
         OP_ADDR: begin
            if (op_hlt || op_illegal) begin
               next_state = HALTED;
            end else begin
               inc_pc     = 1'b1;
               next_state = OP_FETCH;
            end
         end
         OP_FETCH: begin
            rd = op_alu;
            if (op_alu && !mem_ready) begin
               if (timeout) next_state = HALTED;
            end else begin
               next_state = ALU_OP;
            end
         end
         ALU_OP: begin
            rd     = op_alu;
            inc_pc = op_skip && skip_q;
            ld_pc  = op_jmp;
            data_e = op_sto;
            next_state = STORE;
         end
         STORE: begin
            rd     = op_alu;
            ld_ac  = op_alu;
            ld_pc  = op_jmp;
            wr     = op_sto;
            data_e = op_sto;
            if (op_sto && !mem_ready) begin
               if (timeout) next_state = HALTED;
            end else begin
               next_state = INST_ADDR;
            end
         end
         HALTED: begin
            if (go) next_state = RESUME;
         end
         RESUME: begin
            inc_pc     = resume_inc;
            next_state = INST_ADDR;
         end
         default: next_state = INST_ADDR;
      endcase
   end

   assign halt    = (state == HALTED);
   assign state_o = state;

endmodule
